bpu_pht: RTL and testbench

Parametrised pattern history table for the branch prediction unit: an array of `2**IDX_W` saturating counters of `CTR_W` bits each. It replaces the single 2-bit counter predictor. The fetch stage reads it combinationally with a PC-derived index. The execute stage updates it with the resolved branch outcome. An optional global-history (gshare) index hash is compiled in by macro.

---
 rtl/bpu_pht.sv | 72 +++++++
 tb/tb_bpu_pht.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bpu_pht.sv
// Pattern history table of 2**IDX_W saturating CTR_W-bit counters with a combinational lookup.
// Optional gshare index hashing is compiled in when BPU_GSHARE_EN is defined.
module bpu_pht #(
   parameter int CTR_W = 2,
   parameter int IDX_W = 6
) (
   input  logic             in_Clk,
   input  logic             in_Rst_N,
   input  logic [IDX_W-1:0] in_rd_idx,
   output logic [IDX_W-1:0] out_rd_hidx,
   output logic [CTR_W-1:0] out_ctr,
   output logic             out_prediction,
   input  logic             in_upd_en,
   input  logic [IDX_W-1:0] in_upd_idx,
   input  logic             in_upd_taken,
   input  logic             in_clr
);

   localparam int              DEPTH   = 2**IDX_W;
   localparam logic [CTR_W-1:0] WNT     = {1'b0, {(CTR_W-1){1'b1}}};
   localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0] CTR_ONE = {{(CTR_W-1){1'b0}}, 1'b1};

   logic [CTR_W-1:0] ctr_reg [DEPTH];
   logic [CTR_W-1:0] upd_cur;
   logic [CTR_W-1:0] upd_next;
   logic [IDX_W-1:0] hidx;

`ifdef BPU_GSHARE_EN
   logic [IDX_W-1:0] ghr_reg;

   // History keeps shifting even across a table clear; only reset zeroes it.
   always_ff @(posedge in_Clk or negedge in_Rst_N) begin
      if (!in_Rst_N) begin
         ghr_reg <= '0;
      end else if (in_upd_en) begin
         ghr_reg <= {ghr_reg[IDX_W-2:0], in_upd_taken};
      end
   end

   assign hidx = in_rd_idx ^ ghr_reg;
`else
   assign hidx = in_rd_idx;
`endif

   assign upd_cur = ctr_reg[in_upd_idx];

   always_comb begin
      upd_next = upd_cur;
      if (in_upd_taken) begin
         if (upd_cur != CTR_MAX) upd_next = upd_cur + CTR_ONE;
      end else begin
         if (upd_cur != '0) upd_next = upd_cur - CTR_ONE;
      end
   end

   always_ff @(posedge in_Clk or negedge in_Rst_N) begin
      if (!in_Rst_N) begin
         for (int i = 0; i < DEPTH; i++) ctr_reg[i] <= WNT;
      end else if (in_clr) begin
         for (int i = 0; i < DEPTH; i++) ctr_reg[i] <= WNT;
      end else if (in_upd_en) begin
         ctr_reg[in_upd_idx] <= upd_next;
      end
   end

   // Reads see the pre-update value during a same-index write.
   assign out_rd_hidx    = hidx;
   assign out_ctr        = ctr_reg[hidx];
   assign out_prediction = ctr_reg[hidx][CTR_W-1];

endmodule

// File: tb/tb_bpu_pht.sv
// Randomised and directed bench for bpu_pht against a table-of-integers reference model.
// Model honours BPU_GSHARE_EN when the macro is defined for the build.
module tb_bpu_pht;
   localparam int CTR_W = 2;
   localparam int IDX_W = 6;
   localparam int DEPTH = 64;
   localparam int WNT   = 1;
   localparam int CMAX  = 3;

   logic             in_Clk;
   logic             in_Rst_N;
   logic [IDX_W-1:0] in_rd_idx;
   logic [IDX_W-1:0] out_rd_hidx;
   logic [CTR_W-1:0] out_ctr;
   logic             out_prediction;
   logic             in_upd_en;
   logic [IDX_W-1:0] in_upd_idx;
   logic             in_upd_taken;
   logic             in_clr;

   logic [3:0] w_rd_idx;
   logic [3:0] w_rd_hidx;
   logic [2:0] w_ctr;
   logic       w_prediction;
   logic       w_upd_en;
   logic [3:0] w_upd_idx;
   logic       w_upd_taken;
   logic       w_clr;

   int n_checks = 0;
   int n_errors = 0;
   int m_ctr [DEPTH];
   int m_ghr;

   bpu_pht #(.CTR_W(CTR_W), .IDX_W(IDX_W)) dut (
      .in_Clk(in_Clk), .in_Rst_N(in_Rst_N), .in_rd_idx(in_rd_idx),
      .out_rd_hidx(out_rd_hidx), .out_ctr(out_ctr), .out_prediction(out_prediction),
      .in_upd_en(in_upd_en), .in_upd_idx(in_upd_idx), .in_upd_taken(in_upd_taken),
      .in_clr(in_clr)
   );

   bpu_pht #(.CTR_W(3), .IDX_W(4)) dut_wide (
      .in_Clk(in_Clk), .in_Rst_N(in_Rst_N), .in_rd_idx(w_rd_idx),
      .out_rd_hidx(w_rd_hidx), .out_ctr(w_ctr), .out_prediction(w_prediction),
      .in_upd_en(w_upd_en), .in_upd_idx(w_upd_idx), .in_upd_taken(w_upd_taken),
      .in_clr(w_clr)
   );

   initial in_Clk = 1'b0;
   always #5 in_Clk = ~in_Clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int hash(input int idx);
`ifdef BPU_GSHARE_EN
      return (idx ^ m_ghr) & (DEPTH - 1);
`else
      return idx;
`endif
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) m_ctr[i] = WNT;
      m_ghr = 0;
   endfunction

   // Called at posedge+1: drive, check the combinational read, clock, advance model.
   task automatic cycle(input int tgt, input int en, input int uidx, input int taken,
                        input int clr, input int exp_ctr);
      int rd;
      rd = tgt;
`ifdef BPU_GSHARE_EN
      rd = tgt ^ m_ghr;
`endif
      in_rd_idx    = IDX_W'(rd);
      in_upd_en    = en[0];
      in_upd_idx   = IDX_W'(uidx);
      in_upd_taken = taken[0];
      in_clr       = clr[0];
      #2;
      check("hidx", int'(out_rd_hidx), hash(rd));
      check("ctr", int'(out_ctr), m_ctr[hash(rd)]);
      check("pred", int'(out_prediction), m_ctr[hash(rd)] >> (CTR_W - 1));
      if (exp_ctr >= 0) check("plan_ctr", int'(out_ctr), exp_ctr);
      $display("cyc rd=%0d en=%0d uidx=%0d t=%0d clr=%0d ctr=%0d", rd, en, uidx, taken, clr, out_ctr);
      @(posedge in_Clk);
      if (clr != 0) begin
         for (int i = 0; i < DEPTH; i++) m_ctr[i] = WNT;
      end else if (en != 0) begin
         if (taken != 0) m_ctr[uidx] = (m_ctr[uidx] < CMAX) ? m_ctr[uidx] + 1 : CMAX;
         else            m_ctr[uidx] = (m_ctr[uidx] > 0) ? m_ctr[uidx] - 1 : 0;
      end
      if (en != 0) m_ghr = ((m_ghr << 1) | (taken & 1)) & (DEPTH - 1);
      #1;
   endtask

   task automatic async_reset();
      in_upd_en = 1'b0;
      in_clr    = 1'b0;
      in_Rst_N  = 1'b0;
      #1;
      model_reset();
      check("rst_ctr", int'(out_ctr), WNT);
      check("rst_hidx", int'(out_rd_hidx), int'(in_rd_idx));
      $display("async reset rd=%0d ctr=%0d", in_rd_idx, out_ctr);
      in_Rst_N = 1'b1;
      #1;
   endtask

   initial begin
      int wghr;
      int e_cnt;
      in_Rst_N = 1'b0; in_rd_idx = '0; in_upd_en = 1'b0; in_upd_idx = '0;
      in_upd_taken = 1'b0; in_clr = 1'b0;
      w_rd_idx = '0; w_upd_en = 1'b0; w_upd_idx = '0; w_upd_taken = 1'b0; w_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge in_Clk);
      #1;
      in_Rst_N = 1'b1;

      // Reset sweep
      for (int i = 0; i < DEPTH; i++) begin
         in_rd_idx = IDX_W'(i);
         #0.1;
         check("sweep_ctr", int'(out_ctr), 1);
         check("sweep_pred", int'(out_prediction), 0);
         check("sweep_hidx", int'(out_rd_hidx), i);
      end
      $display("reset sweep done");
      @(posedge in_Clk);
      #1;

      // Wide counter instance: WNT 3, saturates at 7
      wghr = 0;
      for (int k = 0; k < 7; k++) begin
         int wrd;
         wrd = 2;
`ifdef BPU_GSHARE_EN
         wrd = 2 ^ wghr;
`endif
         w_rd_idx = 4'(wrd);
         w_upd_en = (k < 6);
         w_upd_idx = 4'd2;
         w_upd_taken = 1'b1;
         #2;
         e_cnt = (3 + k > 7) ? 7 : 3 + k;
         check("wide_ctr", int'(w_ctr), e_cnt);
         check("wide_pred", int'(w_prediction), (k >= 1) ? 1 : 0);
         $display("wide k=%0d ctr=%0d pred=%0d", k, w_ctr, w_prediction);
         @(posedge in_Clk);
         if (k < 6) wghr = ((wghr << 1) | 1) & 15;
         #1;
      end
      w_upd_en = 1'b0;

      // Saturation up then down on idx 5
      for (int k = 0; k < 4; k++) cycle(5, 1, 5, 1, 0, (k == 0) ? 1 : (k == 1) ? 2 : 3);
      for (int k = 0; k < 5; k++) cycle(5, 1, 5, 0, 0, (k == 0) ? 3 : (k == 1) ? 2 : (k == 2) ? 1 : 0);
      cycle(5, 0, 0, 0, 0, 0);
      cycle(4, 0, 0, 0, 0, 1);
      cycle(6, 0, 0, 0, 0, 1);

      // Read-during-write on idx 9
      cycle(9, 1, 9, 1, 0, 1);
      cycle(9, 0, 0, 0, 0, 2);

      // Clear beats a simultaneous update
      cycle(3, 1, 3, 1, 0, 1);
      cycle(3, 1, 3, 1, 0, 2);
      cycle(3, 1, 3, 1, 1, 3);
      for (int i = 0; i < DEPTH; i++) cycle(i, 0, 0, 0, 0, 1);

      // Gshare hashing from a fresh history
      async_reset();
      cycle(0, 1, 0, 1, 0, -1);
      cycle(0, 1, 0, 0, 0, -1);
      cycle(0, 1, 0, 1, 0, -1);
      in_upd_en = 1'b0;
      in_rd_idx = 6'h0F;
      #1;
`ifdef BPU_GSHARE_EN
      check("gshare_hidx", int'(out_rd_hidx), 'h0A);
`else
      check("gshare_hidx", int'(out_rd_hidx), 'h0F);
`endif
      $display("gshare rd=0x0F hidx=0x%0h", out_rd_hidx);
      @(posedge in_Clk);
      #1;

      // Random traffic with occasional mid-cycle asynchronous reset
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) == 0) async_reset();
         cycle($urandom_range(0, DEPTH - 1), ($urandom_range(0, 2) != 0) ? 1 : 0,
               ($urandom_range(0, 3) == 0) ? 5 : $urandom_range(0, DEPTH - 1),
               $urandom_range(0, 1), ($urandom_range(0, 39) == 0) ? 1 : 0, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
